pwr_island_out_seq: RTL and testbench

- Sequencer for the output (domain-boundary) side of a switchable low-voltage island.
- Its outputs reach the always-on domain through level-shifter/isolation cells.
- Orders the power switch, retention save/restore and isolation clamps for power-up and power-down, using a req/ack handshake toward the system power controller.
- Sits in the always-on domain, one instance per switchable island.

---
 rtl/pwr_seq_pkg.sv | 44 ++++
 rtl/pwr_seq_timer.sv | 28 ++
 rtl/pwr_island_out_seq.sv | 220 ++++++++++++++++++++++
 tb/tb_pwr_island_out_seq.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/pwr_seq_pkg.sv
// Shared types and constants for the power-island output sequencer.
// The optional retention path is selected by PWR_SEQ_RETENTION_EN.
package pwr_seq_pkg;

    typedef enum logic [3:0] {
        ST_OFF,
        ST_PU_SW,
        ST_PU_SETTLE,
        ST_PU_RESTORE,
        ST_PU_UNISO,
        ST_ON,
        ST_PD_ISO,
        ST_PD_SAVE,
        ST_PD_SW,
        ST_ERR
    } seq_state_t;

    // Registered output bundle, one bit per sequencer output.
    typedef struct packed {
        logic sw_en;
        logic iso_en;
        logic ret_save;
        logic ret_restore;
        logic pwr_ack;
        logic busy;
        logic err;
    } seq_out_t;

    localparam int DEF_SETTLE_CYC    = 16;
    localparam int DEF_ISO_CYC       = 4;
    localparam int DEF_RET_PULSE_CYC = 2;
    localparam int DEF_TIMEOUT_CYC   = 1024;

    // Width of the shared down-counter: enough for the largest cycle count.
    function automatic int cnt_width(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return $clog2(m) + 1;
    endfunction

endpackage

// File: rtl/pwr_seq_timer.sv
// Loadable saturating down-counter with zero flag, shared by all timed
// states of the power-island sequencer. Independent of PWR_SEQ_RETENTION_EN.
module pwr_seq_timer #(
    parameter int CNT_W = 11
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             zero
);

    logic [CNT_W-1:0] cnt;

    // Load has priority; otherwise count down and stick at zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/pwr_island_out_seq.sv
// Output-side sequencer for a switchable low-voltage island: orders the
// power switch, retention save/restore and isolation clamps, with a
// req/ack handshake toward the system power controller.
// Build option: define PWR_SEQ_RETENTION_EN to include the retention
// save/restore steps; without it those steps are skipped and the
// ret_save/ret_restore outputs are tied low.
module pwr_island_out_seq
    import pwr_seq_pkg::*;
#(
    parameter int SETTLE_CYC    = DEF_SETTLE_CYC,
    parameter int ISO_CYC       = DEF_ISO_CYC,
    parameter int RET_PULSE_CYC = DEF_RET_PULSE_CYC,
    parameter int TIMEOUT_CYC   = DEF_TIMEOUT_CYC
) (
    input  logic clk,
    input  logic rst,
    input  logic pwr_req,
    output logic pwr_ack,
    output logic busy,
    output logic sw_en,
    input  logic sw_ack,
    output logic iso_en,
    output logic ret_save,
    output logic ret_restore,
    output logic err,
    input  logic err_clr
);

    localparam int CNT_W = cnt_width(SETTLE_CYC, ISO_CYC, RET_PULSE_CYC, TIMEOUT_CYC);

    // A load of N-1 makes a timed state last exactly N cycles.
    localparam logic [CNT_W-1:0] LD_SETTLE  = CNT_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0] LD_ISO     = CNT_W'(ISO_CYC - 1);
    localparam logic [CNT_W-1:0] LD_TIMEOUT = CNT_W'(TIMEOUT_CYC - 1);
`ifdef PWR_SEQ_RETENTION_EN
    localparam logic [CNT_W-1:0] LD_RET     = CNT_W'(RET_PULSE_CYC - 1);
`endif

    seq_state_t       state_q;
    seq_state_t       state_d;
    seq_out_t         out_q;
    logic             tmr_load;
    logic [CNT_W-1:0] tmr_val;
    logic             tmr_zero;

    // Output decode for a given state; clamps stay on everywhere except
    // while un-isolating and in ON, so the island is never unclamped while
    // its supply or retention contents are in flux.
    function automatic seq_out_t out_of(input seq_state_t st);
        seq_out_t o;
        o        = '0;
        o.iso_en = 1'b1;
        case (st)
            ST_PU_SW, ST_PU_SETTLE, ST_PD_ISO: begin
                o.sw_en = 1'b1;
                o.busy  = 1'b1;
            end
            ST_PU_RESTORE: begin
                o.sw_en       = 1'b1;
                o.busy        = 1'b1;
                o.ret_restore = 1'b1;
            end
            ST_PU_UNISO: begin
                o.sw_en  = 1'b1;
                o.busy   = 1'b1;
                o.iso_en = 1'b0;
            end
            ST_ON: begin
                o.sw_en   = 1'b1;
                o.iso_en  = 1'b0;
                o.pwr_ack = 1'b1;
            end
            ST_PD_SAVE: begin
                o.sw_en    = 1'b1;
                o.busy     = 1'b1;
                o.ret_save = 1'b1;
            end
            ST_PD_SW: begin
                o.busy = 1'b1;
            end
            ST_ERR: begin
                o.err = 1'b1;
            end
            default: begin
                o.sw_en = 1'b0;
            end
        endcase
`ifndef PWR_SEQ_RETENTION_EN
        o.ret_save    = 1'b0;
        o.ret_restore = 1'b0;
`endif
        return o;
    endfunction

    pwr_seq_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .zero     (tmr_zero)
    );

    // Next-state and timer-load decode; pwr_req is only looked at in OFF/ON.
    always_comb begin
        state_d  = state_q;
        tmr_load = 1'b0;
        tmr_val  = '0;
        case (state_q)
            ST_OFF: begin
                if (pwr_req) begin
                    state_d  = ST_PU_SW;
                    tmr_load = 1'b1;
                    tmr_val  = LD_TIMEOUT;
                end
            end
            ST_PU_SW: begin
                if (sw_ack) begin
                    state_d  = ST_PU_SETTLE;
                    tmr_load = 1'b1;
                    tmr_val  = LD_SETTLE;
                end else if (tmr_zero) begin
                    state_d = ST_ERR;
                end
            end
            ST_PU_SETTLE: begin
                if (tmr_zero) begin
`ifdef PWR_SEQ_RETENTION_EN
                    state_d  = ST_PU_RESTORE;
                    tmr_load = 1'b1;
                    tmr_val  = LD_RET;
`else
                    state_d  = ST_PU_UNISO;
                    tmr_load = 1'b1;
                    tmr_val  = LD_ISO;
`endif
                end
            end
`ifdef PWR_SEQ_RETENTION_EN
            ST_PU_RESTORE: begin
                if (tmr_zero) begin
                    state_d  = ST_PU_UNISO;
                    tmr_load = 1'b1;
                    tmr_val  = LD_ISO;
                end
            end
`endif
            ST_PU_UNISO: begin
                if (tmr_zero) begin
                    state_d = ST_ON;
                end
            end
            ST_ON: begin
                if (!pwr_req) begin
                    state_d  = ST_PD_ISO;
                    tmr_load = 1'b1;
                    tmr_val  = LD_ISO;
                end
            end
            ST_PD_ISO: begin
                if (tmr_zero) begin
`ifdef PWR_SEQ_RETENTION_EN
                    state_d  = ST_PD_SAVE;
                    tmr_load = 1'b1;
                    tmr_val  = LD_RET;
`else
                    state_d  = ST_PD_SW;
                    tmr_load = 1'b1;
                    tmr_val  = LD_TIMEOUT;
`endif
                end
            end
`ifdef PWR_SEQ_RETENTION_EN
            ST_PD_SAVE: begin
                if (tmr_zero) begin
                    state_d  = ST_PD_SW;
                    tmr_load = 1'b1;
                    tmr_val  = LD_TIMEOUT;
                end
            end
`endif
            ST_PD_SW: begin
                if (!sw_ack) begin
                    state_d = ST_OFF;
                end else if (tmr_zero) begin
                    state_d = ST_ERR;
                end
            end
            ST_ERR: begin
                if (err_clr) begin
                    state_d = ST_OFF;
                end
            end
            default: begin
                state_d = ST_OFF;
            end
        endcase
    end

    // State register with outputs registered from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_OFF;
            out_q   <= out_of(ST_OFF);
        end else begin
            state_q <= state_d;
            out_q   <= out_of(state_d);
        end
    end

    assign sw_en       = out_q.sw_en;
    assign iso_en      = out_q.iso_en;
    assign ret_save    = out_q.ret_save;
    assign ret_restore = out_q.ret_restore;
    assign pwr_ack     = out_q.pwr_ack;
    assign busy        = out_q.busy;
    assign err         = out_q.err;

endmodule

// File: tb/tb_pwr_island_out_seq.sv
// Directed bench for pwr_island_out_seq with a queue of expected results.
// Expectations follow PWR_SEQ_RETENTION_EN when the bench is built with it.
module tb_pwr_island_out_seq;

    localparam int SETTLE_CYC = 16;
    localparam int ISO_CYC    = 4;
    localparam int TIMEOUT    = 1024;
    localparam int SW_DLY     = 5;
    localparam int SW_OFF_DLY = 3;
`ifdef PWR_SEQ_RETENTION_EN
    localparam int RET_W = 2;
`else
    localparam int RET_W = 0;
`endif
    localparam int PD_SAVE_T = (RET_W > 0) ? 1 + ISO_CYC : -1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic pwr_req = 1'b0;
    logic sw_ack = 1'b0;
    logic err_clr = 1'b0;
    logic pwr_ack, busy, sw_en, iso_en, ret_save, ret_restore, err;

    typedef struct {
        string  tag;
        integer val;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    pwr_island_out_seq dut (
        .clk         (clk),
        .rst         (rst),
        .pwr_req     (pwr_req),
        .pwr_ack     (pwr_ack),
        .busy        (busy),
        .sw_en       (sw_en),
        .sw_ack      (sw_ack),
        .iso_en      (iso_en),
        .ret_save    (ret_save),
        .ret_restore (ret_restore),
        .err         (err),
        .err_clr     (err_clr)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sb_push(input string tag, input integer v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic chk(input integer obs);
        exp_t e;
        tests++;
        if (sb.size() == 0) begin
            fails++;
            $error("FAIL sb_empty: observed %0d, expected an entry", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val) else begin
                fails++;
                $error("FAIL %s: observed %0d, expected %0d", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic chk_reset_outputs(input string pfx);
        sb_push({pfx, "_sw_en"}, 0);       chk(sw_en);
        sb_push({pfx, "_iso_en"}, 1);      chk(iso_en);
        sb_push({pfx, "_ret_save"}, 0);    chk(ret_save);
        sb_push({pfx, "_ret_restore"}, 0); chk(ret_restore);
        sb_push({pfx, "_pwr_ack"}, 0);     chk(pwr_ack);
        sb_push({pfx, "_busy"}, 0);        chk(busy);
        sb_push({pfx, "_err"}, 0);         chk(err);
    endtask

    // Power-up from OFF; the island model raises sw_ack SW_DLY cycles after
    // sw_en. drop_at > 0 withdraws the request at that cycle.
    task automatic power_up(input int drop_at);
        int t_sw = -1, t_iso = -1, t_ack = -1, n_rest = 0, n_save = 0, n_both = 0;
        sb_push("pu_sw_en_lat", 1);
        sb_push("pu_ack_lat", 1 + SW_DLY + 1 + SETTLE_CYC + RET_W + ISO_CYC);
        sb_push("pu_restore_width", RET_W);
        sb_push("pu_iso_lead", ISO_CYC);
        sb_push("pu_no_save", 0);
        sb_push("pu_ret_exclusive", 0);
        sb_push("pu_on_busy", 0);
        sb_push("pu_on_sw_en", 1);
        pwr_req = 1'b1;
        for (int t = 1; t <= 200 && t_ack < 0; t++) begin
            tick();
            if (sw_en && t_sw < 0) t_sw = t;
            if (t_sw > 0 && t == t_sw + SW_DLY) sw_ack = 1'b1;
            if (drop_at > 0 && t == drop_at) pwr_req = 1'b0;
            if (ret_restore) n_rest++;
            if (ret_save) n_save++;
            if (ret_save && ret_restore) n_both++;
            if (!iso_en && t_iso < 0) t_iso = t;
            if (pwr_ack) t_ack = t;
        end
        chk(t_sw);
        chk(t_ack);
        chk(n_rest);
        chk(t_ack - t_iso);
        chk(n_save);
        chk(n_both);
        chk(busy);
        chk(sw_en);
    endtask

    // Power-down from ON; the island model drops sw_ack SW_OFF_DLY cycles
    // after sw_en falls. drive = 0 when pwr_req is already low.
    task automatic power_down(input bit drive);
        int t_save = -1, n_save = 0, t_swoff = -1, t_idle = -1, n_unclamped = 0, n_rest = 0;
        if (drive) pwr_req = 1'b0;
        sb_push("pd_ack_drop", 0);
        sb_push("pd_iso_on", 1);
        tick();
        chk(pwr_ack);
        chk(iso_en);
        sb_push("pd_save_start", PD_SAVE_T);
        sb_push("pd_save_width", RET_W);
        sb_push("pd_sw_off_lat", ISO_CYC + RET_W);
        sb_push("pd_idle_after_sw_off", SW_OFF_DLY + 1);
        sb_push("pd_iso_held", 0);
        sb_push("pd_no_restore", 0);
        sb_push("pd_off_sw_en", 0);
        sb_push("pd_off_ack", 0);
        for (int t = 2; t <= 2000 && t_idle < 0; t++) begin
            tick();
            if (ret_save && t_save < 0) t_save = t;
            if (ret_save) n_save++;
            if (ret_restore) n_rest++;
            if (!iso_en) n_unclamped++;
            if (!sw_en && t_swoff < 0) t_swoff = t;
            if (t_swoff > 0 && t == t_swoff + SW_OFF_DLY) sw_ack = 1'b0;
            if (!busy) t_idle = t;
        end
        chk(t_save);
        chk(n_save);
        chk(t_swoff - 1);
        chk(t_idle - t_swoff);
        chk(n_unclamped);
        chk(n_rest);
        chk(sw_en);
        chk(pwr_ack);
    endtask

    initial begin
        int t_err;

        // Reset state
        repeat (3) tick();
        rst = 1'b0;
        chk_reset_outputs("rst");

        // Normal power-up then power-down
        power_up(0);
        power_down(1'b1);

        // Timeout waiting for sw_ack
        pwr_req = 1'b1;
        sw_ack  = 1'b0;
        t_err   = -1;
        sb_push("to_lat", 1 + TIMEOUT);
        for (int t = 1; t <= TIMEOUT + 100 && t_err < 0; t++) begin
            tick();
            if (err) t_err = t;
        end
        chk(t_err);
        sb_push("to_sw_en", 0);  chk(sw_en);
        sb_push("to_iso_en", 1); chk(iso_en);
        sb_push("to_busy", 0);   chk(busy);
        repeat (3) tick();
        sb_push("err_sticky", 1);      chk(err);
        sb_push("err_req_ignored", 0); chk(sw_en);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        sb_push("err_clr_err", 0);   chk(err);
        sb_push("err_clr_sw_en", 0); chk(sw_en);
        sb_push("err_clr_busy", 0);  chk(busy);
        power_up(0);
        power_down(1'b1);

        // Request withdrawn during settling
        power_up(1 + SW_DLY + 1 + 5);
        power_down(1'b0);

        // Reset in the middle of power-down
        power_up(0);
        pwr_req = 1'b0;
        repeat ((RET_W > 0) ? 1 + ISO_CYC : 2) tick();
        sb_push("mid_ret_save", (RET_W > 0) ? 1 : 0); chk(ret_save);
        sb_push("mid_busy", 1);                       chk(busy);
        rst = 1'b1;
        tick();
        chk_reset_outputs("mid_rst");
        rst    = 1'b0;
        sw_ack = 1'b0;
        repeat (2) tick();
        sb_push("post_rst_idle", 0); chk(busy);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
